// File: rtl/mips_pkg.sv
// Shared constants and the in-flight producer record for the ID-stage forwarding/hazard logic.
package mips_pkg;
  localparam int REG_AW      = 5;
  localparam int SEL_REGFILE = 0;
  localparam int STG_EXE     = 1;
  localparam int STG_MEM     = 2;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb_en;
    logic              mem_read;
  } fwd_rec_t;

  localparam fwd_rec_t REC_BUBBLE = '0;
endpackage

// File: rtl/fwd_src_match.sv
// One ID source field against the tracked producer records.
// Yields the youngest bypass select and whether this source forces a stall.
module fwd_src_match
  import mips_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int LOAD_STAGES = 1,
  parameter int SEL_W       = 2
) (
  input  logic                  fwd_en,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     src,
  input  fwd_rec_t [DEPTH:1]    rec,
  output logic [SEL_W-1:0]      sel,
  output logic                  stall_req
);

  // Walk oldest to youngest so the youngest hit overwrites sel last.
  always_comb begin
    sel       = SEL_W'(SEL_REGFILE);
    stall_req = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && rec[k].valid && rec[k].wb_en &&
          rec[k].dest == src && src != REG_ZERO) begin
        if (fwd_en) sel = SEL_W'(k);
        if (!fwd_en || (k <= LOAD_STAGES && rec[k].mem_read)) stall_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding + hazard unit beside ID: tracks DEPTH in-flight producers, drives per-source
// bypass selects, load-use / no-forward stall, and a saturating stall-cycle counter.
module fwd_hazard_scoreboard #(
  parameter int  NUM_SRC     = 3,
  parameter int  REG_AW      = 5,
  parameter int  DEPTH       = 2,
  parameter int  LOAD_STAGES = 1,
  parameter int  CNT_W       = 16,
  localparam int SEL_W       = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      id_wb_en,
  input  logic                      id_mem_read,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]          stall_cnt
);
  import mips_pkg::*;

  fwd_rec_t [DEPTH:1] rec;
  fwd_rec_t           rec_in;
  logic [NUM_SRC-1:0] src_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .DEPTH       (DEPTH),
      .LOAD_STAGES (LOAD_STAGES),
      .SEL_W       (SEL_W)
    ) u_match (
      .fwd_en    (fwd_en),
      .id_valid  (id_valid),
      .src       (id_src[i*REG_AW +: REG_AW]),
      .rec       (rec),
      .sel       (sel[i*SEL_W +: SEL_W]),
      .stall_req (src_stall[i])
    );
  end

  assign stall = |src_stall;

  always_comb begin
    rec_in          = REC_BUBBLE;
    rec_in.valid    = 1'b1;
    rec_in.dest     = id_dest;
    rec_in.wb_en    = id_wb_en;
    rec_in.mem_read = id_mem_read;
  end

  // Older stages always advance; only the EXE entry takes a bubble on stall/flush/idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec       <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) rec[k] <= rec[k-1];
      rec[1] <= (flush || stall || !id_valid) ? REC_BUBBLE : rec_in;
      if (stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed scenarios for the forwarding/hazard unit with hand-computed expectations.
module tb_fwd_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en, flush, id_valid, id_wb_en, id_mem_read;
  logic [14:0] id_src;
  logic [4:0]  id_dest;
  logic        stall, stall_s;
  logic [5:0]  sel, sel_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  int errors = 0;
  int checks = 0;

  fwd_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .id_valid(id_valid),
    .id_src(id_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .stall(stall), .sel(sel), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance on the same inputs to reach saturation cheaply.
  fwd_hazard_scoreboard #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .flush(flush), .id_valid(id_valid),
    .id_src(id_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .stall(stall_s), .sel(sel_s), .stall_cnt(stall_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d, input logic wb,
                        input logic mr);
    id_valid = v; id_src = {s2, s1, s0}; id_dest = d; id_wb_en = wb; id_mem_read = mr;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fwd_en = 1'b1; flush = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fwd_en = 1'b1; flush = 1'b0;
    set_id(1'b1, 5'd3, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b want=0", stall); end
    checks++; if (sel !== 6'd0) begin errors++; $display("FAIL reset_sel got=%b want=000000", sel); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0);   // add $3
    tick();
    set_id(1'b1, 5'd3, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0);   // sub reads $3
    checks++; if (sel !== 6'b000001) begin errors++; $display("FAIL alu_sel_exe got=%b want=000001", sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%0b want=0", stall); end
    set_id(1'b0, 5'd3, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0);
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL alu_idvalid0 got=%b want=000000", sel); end
    set_id(1'b1, 5'd3, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd8, 5'd3, 5'd0, 5'd9, 1'b1, 1'b0);   // unrelated reader of $3
    checks++; if (sel !== 6'b001000) begin errors++; $display("FAIL alu_sel_mem got=%b want=001000", sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);   // lw $4
    tick();
    set_id(1'b1, 5'd4, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0);   // add $5,$4,$4
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b want=1", stall); end
    checks++; if (sel !== 6'b000101) begin errors++; $display("FAIL lu_sel_stall got=%b want=000101", sel); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%0b want=0", stall); end
    checks++; if (sel !== 6'b001010) begin errors++; $display("FAIL lu_sel_mem got=%b want=001010", sel); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
    tick();
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL lu_bubble_drained got=%b want=000000", sel); end
  endtask

  task automatic test_youngest();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b0);   // add $7
    tick();
    set_id(1'b1, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);   // addi $7,$7
    checks++; if (sel !== 6'b000001) begin errors++; $display("FAIL yw_addi got=%b want=000001", sel); end
    tick();
    set_id(1'b1, 5'd7, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);   // or using $7 everywhere
    checks++; if (sel !== 6'b010101) begin errors++; $display("FAIL yw_sel got=%b want=010101", sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL yw_stall got=%0b want=0", stall); end
  endtask

  task automatic test_zero_nowb();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1);   // lw $0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1);   // reads $0, writes nothing
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%0b want=0", stall); end
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL zero_sel got=%b want=000000", sel); end
    tick();
    set_id(1'b1, 5'd9, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL nowb_sel got=%b want=000000", sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nowb_stall got=%0b want=0", stall); end
  endtask

  task automatic test_fwd_disabled();
    do_reset();
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0);   // add $2
    tick();
    set_id(1'b1, 5'd2, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nf_stall1 got=%0b want=1", stall); end
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL nf_sel1 got=%b want=000000", sel); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nf_stall2 got=%0b want=1", stall); end
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL nf_sel2 got=%b want=000000", sel); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nf_release got=%0b want=0", stall); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL nf_cnt got=%0d want=2", stall_cnt); end
    checks++; if (stall_cnt_s !== 2'd2) begin errors++; $display("FAIL nf_cnt_narrow got=%0d want=2", stall_cnt_s); end
    tick();
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0);
    tick();
    tick();
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL nf_cnt4 got=%0d want=4", stall_cnt); end
    checks++; if (stall_cnt_s !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d want=3", stall_cnt_s); end
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd12, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL toggle_off got=%0b want=1", stall); end
    fwd_en = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL toggle_on_stall got=%0b want=0", stall); end
    checks++; if (sel !== 6'b000001) begin errors++; $display("FAIL toggle_on_sel got=%b want=000001", sel); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);   // lw $4
    tick();
    set_id(1'b1, 5'd4, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_stall got=%0b want=1", stall); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL fl_cnt got=%0d want=0", stall_cnt); end
    checks++; if (sel !== 6'b000010) begin errors++; $display("FAIL fl_bubble got=%b want=000010", sel); end
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);   // lw $5
    tick();
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1);   // lw $6
    tick();
    set_id(1'b1, 5'd6, 5'd6, 5'd0, 5'd8, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rs_pre_stall got=%0b want=1", stall); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL rs_pre_cnt got=%0d want=1", stall_cnt); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rs_stall got=%0b want=0", stall); end
    checks++; if (sel !== 6'b000000) begin errors++; $display("FAIL rs_sel got=%b want=000000", sel); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rs_cnt got=%0d want=0", stall_cnt); end
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_zero_nowb();
    test_fwd_disabled();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
